// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle 4-bit divider.
// A granted request has its operands latched. Divide-by-zero is answered
// locally without starting the divider. Other requests wait until IDLE.
module div_arbiter #(
   parameter int DIV_LATENCY = 5
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       reqA,
   input  logic       reqB,
   input  logic [3:0] dividendA,
   input  logic [3:0] divisorA,
   input  logic [3:0] dividendB,
   input  logic [3:0] divisorB,
   output logic       gntA,
   output logic       gntB,
   output logic       done,
   output logic       result_id,
   output logic [3:0] quotient,
   output logic [3:0] remainder,
   output logic       dz_err,
   output logic       busy,
   output logic       div_go,
   output logic [3:0] div_dividend,
   output logic [3:0] div_divisor,
   input  logic [3:0] div_quotient,
   input  logic [3:0] div_remainder
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t     state, state_nxt;
   logic       ptr;          // 0 = A has priority on a tie, 1 = B
   logic       op_id;
   logic       win_id;
   logic       div_zero;
   logic [3:0] cnt;
   logic [3:0] op_dividend;
   logic [3:0] op_divisor;

   // A lone requester wins outright; a tie goes to the pointer side.
   assign win_id   = (reqA && reqB) ? ptr : reqB;
   assign div_zero = (op_divisor == 4'd0);

   assign div_dividend = op_dividend;
   assign div_divisor  = op_divisor;

   // State register.
   always_ff @(posedge Clock) begin
      if (!Resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and Moore outputs (decoded from state and latched operands).
   always_comb begin
      state_nxt = state;
      gntA      = 1'b0;
      gntB      = 1'b0;
      div_go    = 1'b0;
      done      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:  if (reqA || reqB) state_nxt = ISSUE;
         ISSUE: begin
            gntA      = !op_id;
            gntB      = op_id;
            div_go    = !div_zero;
            state_nxt = div_zero ? DONE : WAIT;
         end
         WAIT:  if (cnt == 4'd1) state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, arbitration pointer, latency counter and result registers.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         ptr         <= 1'b0;
         op_id       <= 1'b0;
         cnt         <= 4'd0;
         op_dividend <= 4'd0;
         op_divisor  <= 4'd0;
         quotient    <= 4'd0;
         remainder   <= 4'd0;
         dz_err      <= 1'b0;
         result_id   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (reqA || reqB) begin
               op_id       <= win_id;
               op_dividend <= win_id ? dividendB : dividendA;
               op_divisor  <= win_id ? divisorB  : divisorA;
               ptr         <= ~win_id;
            end
            ISSUE: begin
               if (!div_zero) begin
                  cnt <= 4'(DIV_LATENCY);
               end else begin
                  quotient  <= 4'hF;
                  remainder <= op_dividend;
                  dz_err    <= 1'b1;
                  result_id <= op_id;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  quotient  <= div_quotient;
                  remainder <= div_remainder;
                  dz_err    <= 1'b0;
                  result_id <= op_id;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
